// File: rtl/rx_fir_filter_param_if.sv
// ---------------------------------------------------------------------------
// rx_fir_filter_param_if
// Purpose : groups the sample stream, coefficient write port and result
//           signals of rx_fir_filter_param into one bundle.
// Signals : idata_in/idata_valid/odata_ready  - sample handshake into filter
//           icoeff_we/icoeff_addr/icoeff_data - coefficient write port
//           ofiltered_sample/ofiltered_valid  - filter result
//           ocoeff_err                        - rejected coefficient write
// Modports: master = sample/coefficient source, slave = the filter.
// ---------------------------------------------------------------------------
interface rx_fir_filter_param_if #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int AW = 7
);
  logic signed [DW-1:0] idata_in;
  logic                 idata_valid;
  logic                 odata_ready;
  logic                 icoeff_we;
  logic [AW-1:0]        icoeff_addr;
  logic signed [CW-1:0] icoeff_data;
  logic signed [DW-1:0] ofiltered_sample;
  logic                 ofiltered_valid;
  logic                 ocoeff_err;

  modport master (
    output idata_in, idata_valid, icoeff_we, icoeff_addr, icoeff_data,
    input  odata_ready, ofiltered_sample, ofiltered_valid, ocoeff_err
  );

  modport slave (
    input  idata_in, idata_valid, icoeff_we, icoeff_addr, icoeff_data,
    output odata_ready, ofiltered_sample, ofiltered_valid, ocoeff_err
  );
endinterface

// File: rtl/rx_fir_filter_param.sv
// ---------------------------------------------------------------------------
// rx_fir_filter_param
// Purpose : time-multiplexed single-MAC FIR filter for the rx chain. Keeps the
//           last NTAPS samples, runs one multiply-accumulate per clock for each
//           accepted sample, then rounds (half up), shifts and reduces to DW.
//           Coefficients are loadable at runtime while the filter is idle.
// Ports   : crx_clk - clock
//           rrx_rst - synchronous active-high reset
//           erx_en  - enable; low clears history/accumulator, keeps coefficients
//           bus     - rx_fir_filter_param_if.slave (sample in, coefficient
//                     write, filtered result, coefficient error pulse)
// Config  : RX_FIR_SAT_EN defined   -> result clamped to the DW signed range
//           RX_FIR_SAT_EN undefined -> result wraps to the low DW bits
// Timing  : accept at edge k -> ofiltered_valid high after edge k+NTAPS+2;
//           one sample every NTAPS+3 clocks.
// ---------------------------------------------------------------------------
module rx_fir_filter_param #(
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int NTAPS     = 128,
  parameter int OUT_SHIFT = 15,
  localparam int AW       = $clog2(NTAPS)
) (
  input  logic                    crx_clk,
  input  logic                    rrx_rst,
  input  logic                    erx_en,
  rx_fir_filter_param_if.slave    bus
);

  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + AW;

  // One extra bit so the rounding constant can never wrap the accumulator.
  localparam logic signed [ACCW:0] ROUND_C = (ACCW+1)'(1) << (OUT_SHIFT - 1);
`ifdef RX_FIR_SAT_EN
  localparam logic signed [ACCW:0] SAT_MAX = {{(ACCW+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] SAT_MIN = {{(ACCW+2-DW){1'b1}}, {(DW-1){1'b0}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FLUSH, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        tap_q, tap_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic                 prod_vld_q, prod_vld_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] out_q, out_d;
  logic                 out_vld_q, out_vld_d;
  logic                 coeff_err_q, coeff_err_d;

  logic signed [DW-1:0] hist_q  [NTAPS];
  logic signed [CW-1:0] coeff_q [NTAPS];

  logic                 idle_en;
  logic                 accept;
  logic                 coeff_wr_ok;
  logic signed [ACCW:0] rnd;
  logic signed [ACCW:0] shifted;

  assign idle_en         = erx_en && (state_q == S_IDLE);
  assign bus.odata_ready = idle_en && !rrx_rst;
  assign accept          = bus.idata_valid && bus.odata_ready;
  assign coeff_wr_ok     = bus.icoeff_we && idle_en;

  assign bus.ofiltered_sample = out_q;
  assign bus.ofiltered_valid  = out_vld_q;
  assign bus.ocoeff_err       = coeff_err_q;

  assign rnd     = {acc_q[ACCW-1], acc_q} + ROUND_C;
  assign shifted = rnd >>> OUT_SHIFT;

  // Sample history and coefficient bank, one register per tap.
  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_taps
    always_ff @(posedge crx_clk) begin
      if (rrx_rst || !erx_en) begin
        hist_q[gi] <= '0;
      end else if (accept && (wr_ptr_q == AW'(gi))) begin
        hist_q[gi] <= bus.idata_in;
      end
    end

    always_ff @(posedge crx_clk) begin
      if (rrx_rst) begin
        coeff_q[gi] <= '0;
      end else if (coeff_wr_ok && (bus.icoeff_addr == AW'(gi))) begin
        coeff_q[gi] <= bus.icoeff_data;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tap_d       = tap_q;
    prod_d      = prod_q;
    prod_vld_d  = 1'b0;
    acc_d       = acc_q;
    out_d       = out_q;
    out_vld_d   = 1'b0;
    // Any write outside an enabled idle cycle is reported one cycle later.
    coeff_err_d = bus.icoeff_we && !idle_en;

    // Products land one cycle after their read; accumulate them as they arrive.
    if (prod_vld_q) begin
      acc_d = acc_q + {{AW{prod_q[PW-1]}}, prod_q};
    end

    if (!erx_en) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      acc_d    = '0;
      out_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d  = S_MAC;
            rd_ptr_d = wr_ptr_q;  // tap 0 reads the sample written this edge
            tap_d    = '0;
            acc_d    = '0;
            wr_ptr_d = (wr_ptr_q == AW'(NTAPS-1)) ? '0 : wr_ptr_q + 1'b1;
          end
        end
        S_MAC: begin
          prod_d     = hist_q[rd_ptr_q] * coeff_q[tap_q];
          prod_vld_d = 1'b1;
          tap_d      = tap_q + 1'b1;
          rd_ptr_d   = (rd_ptr_q == '0) ? AW'(NTAPS-1) : rd_ptr_q - 1'b1;
          if (tap_q == AW'(NTAPS-1)) begin
            state_d = S_FLUSH;
          end
        end
        S_FLUSH: begin
          state_d = S_OUT;
        end
        S_OUT: begin
`ifdef RX_FIR_SAT_EN
          if (shifted > SAT_MAX) begin
            out_d = SAT_MAX[DW-1:0];
          end else if (shifted < SAT_MIN) begin
            out_d = SAT_MIN[DW-1:0];
          end else begin
            out_d = shifted[DW-1:0];
          end
`else
          out_d = shifted[DW-1:0];
`endif
          out_vld_d = 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge crx_clk) begin
    if (rrx_rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tap_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      coeff_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tap_q       <= tap_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      coeff_err_q <= coeff_err_d;
    end
  end

endmodule

// File: tb/tb_rx_fir_filter_param.sv
// ---------------------------------------------------------------------------
// tb_rx_fir_filter_param
// Scoreboard bench for rx_fir_filter_param (NTAPS=8, DW=CW=16, OUT_SHIFT=15).
// The driver pushes the reference model's expected result for each accepted
// sample; an independent monitor pops and compares on every ofiltered_valid.
// ---------------------------------------------------------------------------
module tb_rx_fir_filter_param;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NTAPS = 8;
  localparam int AW = 3;
  localparam int OUT_SHIFT = 15;

  typedef struct {
    logic signed [15:0] val;
    longint             edge_n;
  } exp_t;

  logic clk;
  logic rst;
  logic en;

  rx_fir_filter_param_if #(.DW(DW), .CW(CW), .AW(AW)) bus ();

  rx_fir_filter_param #(
    .DW(DW), .CW(CW), .NTAPS(NTAPS), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .crx_clk(clk),
    .rrx_rst(rst),
    .erx_en (en),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  longint edge_cnt = 0;
  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  int checks = 0;
  int passes = 0;
  exp_t exp_q[$];

  // Reference model: newest sample at the front of the history queue.
  int hist_m[$];
  int coef_m[NTAPS];

  longint last_edge = 0;
  bit     chained = 0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  function automatic logic signed [15:0] model_push(input int x);
    longint acc = 0;
    logic [63:0] accb;
    hist_m.push_front(x);
    if (hist_m.size() > NTAPS) void'(hist_m.pop_back());
    foreach (hist_m[k]) acc += longint'(coef_m[k]) * longint'(hist_m[k]);
    acc = (acc + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
`ifdef RX_FIR_SAT_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    accb = acc;
    return accb[15:0];
  endfunction

  // Monitor: every result must match the oldest outstanding expectation and
  // appear NTAPS+2 edges after its accepting edge.
  always @(negedge clk) begin
    if (bus.ofiltered_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sample", longint'($signed(bus.ofiltered_sample)), longint'(e.val));
        chk("latency", edge_cnt - e.edge_n, NTAPS + 2);
        $display("result %0d (expected %0d) at edge %0d", $signed(bus.ofiltered_sample), e.val, edge_cnt);
      end
    end
  end

  task automatic send(input int x, input bit keep, input bit wc, input int ca, input int cv);
    int waits = 0;
    longint acc_edge;
    exp_t e;
    @(negedge clk);
    bus.idata_in    = 16'(x);
    bus.idata_valid = 1'b1;
    while (!bus.odata_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.odata_ready) begin
      chk("accept_timeout", 0, 1);
      bus.idata_valid = 1'b0;
      chained = 0;
      return;
    end
    if (wc) begin
      bus.icoeff_we   = 1'b1;
      bus.icoeff_addr = AW'(ca);
      bus.icoeff_data = 16'(cv);
      coef_m[ca]      = cv;
    end
    acc_edge = edge_cnt + 1;
    if (chained) begin
      chk("ready_low_cycles", waits, NTAPS + 2);
      chk("accept_spacing", acc_edge - last_edge, NTAPS + 3);
    end
    e.val = model_push(x);
    e.edge_n = acc_edge;
    exp_q.push_back(e);
    $display("accept %0d at edge %0d", x, acc_edge);
    last_edge = acc_edge;
    chained = keep;
    @(posedge clk);
    #1;
    bus.icoeff_we = 1'b0;
    if (!keep) bus.idata_valid = 1'b0;
    if (wc) begin
      @(negedge clk);
      chk("coeff_err_idle_accept", bus.ocoeff_err, 0);
    end
  endtask

  task automatic wr_coeff(input int a, input int v, input bit ok);
    @(negedge clk);
    bus.icoeff_we   = 1'b1;
    bus.icoeff_addr = AW'(a);
    bus.icoeff_data = 16'(v);
    @(posedge clk);
    #1;
    bus.icoeff_we = 1'b0;
    if (ok) coef_m[a] = v;
    @(negedge clk);
    chk("coeff_err", bus.ocoeff_err, ok ? 0 : 1);
    $display("coeff write [%0d]=%0d err=%0b", a, v, bus.ocoeff_err);
  endtask

  task automatic wait_idle();
    repeat (NTAPS + 5) @(negedge clk);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < NTAPS; k++) wr_coeff(k, 2 * (k + 1), 1);
  endtask

  task automatic impulse();
    send(16384, 1, 0, 0, 0);
    for (int i = 1; i < NTAPS; i++) send(0, i != NTAPS - 1, 0, 0, 0);
    wait_idle();
  endtask

  initial begin
    int vcnt;
    rst = 1'b1;
    en  = 1'b1;
    bus.idata_in = '0;
    bus.idata_valid = 1'b0;
    bus.icoeff_we = 1'b0;
    bus.icoeff_addr = '0;
    bus.icoeff_data = '0;
    foreach (coef_m[k]) coef_m[k] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.odata_ready, 0);
    chk("rst_valid", bus.ofiltered_valid, 0);
    chk("rst_sample", bus.ofiltered_sample, 0);
    chk("rst_err", bus.ocoeff_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.odata_ready, 1);

    // Impulse with ramp coefficients, back-to-back handshake
    load_ramp();
    impulse();

    // Overflow: full-scale coefficients and samples
    for (int k = 0; k < NTAPS; k++) wr_coeff(k, 32767, 1);
    for (int i = 0; i < NTAPS; i++) send(32767, i != NTAPS - 1, 0, 0, 0);
    wait_idle();

    // Coefficient write during MAC is rejected
    load_ramp();
    send(1000, 0, 0, 0, 0);
    wr_coeff(2, 999, 0);
    @(negedge clk);
    chk("coeff_err_one_pulse", bus.ocoeff_err, 0);
    wait_idle();
    impulse();
    // Write in idle together with an accept: new value used at once
    send(16384, 0, 1, 0, 100);
    wait_idle();

    // Reset at MAC tap 3
    send(12345, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    hist_m.delete();
    foreach (coef_m[k]) coef_m[k] = 0;
    @(negedge clk);
    chk("abort_rst_sample", bus.ofiltered_sample, 0);
    chk("abort_rst_valid", bus.ofiltered_valid, 0);
    chk("abort_rst_ready", bus.odata_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.ofiltered_valid) vcnt++;
    end
    chk("abort_rst_no_valid", vcnt, 0);
    load_ramp();
    impulse();

    // Enable low for one cycle mid-computation
    send(-20000, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    en = 1'b0;
    exp_q.delete();
    hist_m.delete();
    @(negedge clk);
    chk("en_low_sample", bus.ofiltered_sample, 0);
    chk("en_low_valid", bus.ofiltered_valid, 0);
    chk("en_low_ready", bus.odata_ready, 0);
    en = 1'b1;
    vcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.ofiltered_valid || bus.ofiltered_sample != 0) vcnt++;
    end
    chk("en_low_outputs_zero", vcnt, 0);
    impulse();

    // Randomised coefficients and samples with random gaps
    for (int k = 0; k < NTAPS; k++) wr_coeff(k, int'($urandom_range(0, 65535)) - 32768, 1);
    for (int i = 0; i < 24; i++) begin
      bit keep;
      keep = (i != 23) && ($urandom_range(0, 1) == 1);
      send(int'($urandom_range(0, 65535)) - 32768, keep, 0, 0, 0);
      if (!keep) repeat ($urandom_range(0, 14)) @(negedge clk);
    end

    // Drain
    vcnt = 0;
    while (exp_q.size() != 0 && vcnt < 200) begin
      vcnt++;
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
